// File: rtl/mem_wb_unit_pkg.sv
// Shared constants, encodings and helpers for the memory-access / writeback stage.
package mem_wb_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    WOS_ALU = 2'b00,
    WOS_MEM = 2'b01,
    WOS_PC4 = 2'b10,
    WOS_IMM = 2'b11
  } wos_e;

  typedef enum logic [1:0] {
    WHB_BYTE     = 2'b00,
    WHB_HALF     = 2'b01,
    WHB_WORD     = 2'b10,
    WHB_WORD_ALT = 2'b11
  } whb_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_WB   = 2'b10
  } state_e;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
  } dmem_req_t;

  // Byte accesses are never misaligned; the reserved size code behaves as a word.
  function automatic logic is_misaligned(whb_e whb, logic [1:0] addr_lo);
    case (whb)
      WHB_BYTE: is_misaligned = 1'b0;
      WHB_HALF: is_misaligned = addr_lo[0];
      default:  is_misaligned = (addr_lo != 2'b00);
    endcase
  endfunction

  // Non-memory writeback source; the memory code falls back to the ALU value.
  function automatic logic [XLEN-1:0] wb_mux(wos_e wos, logic [XLEN-1:0] alu,
                                             logic [XLEN-1:0] pc4, logic [XLEN-1:0] imm);
    case (wos)
      WOS_PC4: wb_mux = pc4;
      WOS_IMM: wb_mux = imm;
      default: wb_mux = alu;
    endcase
  endfunction

endpackage

// File: rtl/mem_wb_unit_load_ext.sv
// Load lane extraction: picks the addressed byte/half of a read word and extends it.
module mem_wb_unit_load_ext
  import mem_wb_unit_pkg::*;
(
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  whb_e            whb,
  input  logic            su,
  output logic [XLEN-1:0] ext_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;

  always_comb begin
    byte_c = 8'h00;
    half_c = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (addr_lo)
      2'b00:   byte_c = rdata[7:0];
      2'b01:   byte_c = rdata[15:8];
      2'b10:   byte_c = rdata[23:16];
      default: byte_c = rdata[31:24];
    endcase
  end

  always_comb begin
    case (whb)
      WHB_BYTE: ext_c = {{24{su & byte_c[7]}}, byte_c};
      WHB_HALF: ext_c = {{16{su & half_c[15]}}, half_c};
      default:  ext_c = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_unit.sv
// Memory-access and writeback stage: runs the dmem handshake for loads/stores and
// produces the Data_WB / wb_valid writeback strobe.
module mem_wb_unit
  import mem_wb_unit_pkg::*;
#(
  parameter int unsigned DW      = XLEN,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [6:0]    opcode,
  input  logic [2:0]    func3,
  input  logic [1:0]    wos,
  input  logic [1:0]    whb,
  input  logic          su,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] store_data,
  input  logic [DW-1:0] imm,
  input  logic [DW-1:0] PC_4,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  output logic [3:0]    dmem_wstrb,
  input  logic          dmem_ready,
  input  logic [DW-1:0] dmem_rdata,
  output logic [DW-1:0] Data_WB,
  output logic          wb_valid,
  output logic          misalign,
  output logic          bus_err
);

  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          req_q, req_d;
  dmem_req_t     dreq_q, dreq_d;
  logic          is_load_q, is_load_d;
  wos_e          wos_q, wos_d;
  whb_e          whb_q, whb_d;
  logic          su_q, su_d;
  logic [1:0]    addr_lo_q, addr_lo_d;
  logic [DW-1:0] alt_q, alt_d;
  logic [2:0]    func3_q, func3_d;
  logic          in_ready_q, in_ready_d;
  logic [DW-1:0] data_wb_q, data_wb_d;
  logic          wb_valid_q, wb_valid_d;
  logic          misalign_q, misalign_d;
  logic          bus_err_q, bus_err_d;

  logic          is_store_c;
  logic          is_mem_c;
  logic [DW-1:0] load_ext_c;
  logic          unused_trace_c;

  assign is_store_c = (opcode == OP_STORE);
  assign is_mem_c   = (opcode == OP_LOAD) || is_store_c;

  // func3 is held only for trace visibility.
  assign unused_trace_c = ^func3_q;

  mem_wb_unit_load_ext u_load_ext (
    .rdata   (dmem_rdata),
    .addr_lo (addr_lo_q),
    .whb     (whb_q),
    .su      (su_q),
    .ext_c   (load_ext_c)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    dreq_d     = dreq_q;
    is_load_d  = is_load_q;
    wos_d      = wos_q;
    whb_d      = whb_q;
    su_d       = su_q;
    addr_lo_d  = addr_lo_q;
    alt_d      = alt_q;
    func3_d    = func3_q;
    data_wb_d  = data_wb_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;
    bus_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          is_load_d = (opcode == OP_LOAD);
          wos_d     = wos_e'(wos);
          whb_d     = whb_e'(whb);
          su_d      = su;
          addr_lo_d = alu_result[1:0];
          func3_d   = func3;
          cnt_d     = '0;
          alt_d     = wb_mux(wos_e'(wos), alu_result, PC_4, imm);
          if (!is_mem_c) begin
            data_wb_d  = alt_d;
            wb_valid_d = 1'b1;
            state_d    = ST_WB;
          end else if (is_misaligned(whb_e'(whb), alu_result[1:0])) begin
            misalign_d = 1'b1;
          end else begin
            state_d     = ST_MEM;
            req_d       = 1'b1;
            dreq_d.we   = is_store_c;
            dreq_d.addr = {alu_result[DW-1:2], 2'b00};
            // Replicate store data across lanes; strobes select the live bytes.
            case (whb_e'(whb))
              WHB_BYTE: begin
                dreq_d.wdata = {4{store_data[7:0]}};
                dreq_d.wstrb = 4'b0001 << alu_result[1:0];
              end
              WHB_HALF: begin
                dreq_d.wdata = {2{store_data[15:0]}};
                dreq_d.wstrb = 4'b0011 << {alu_result[1], 1'b0};
              end
              default: begin
                dreq_d.wdata = store_data;
                dreq_d.wstrb = 4'b1111;
              end
            endcase
          end
        end
      end

      ST_MEM: begin
        if (dmem_ready) begin
          req_d  = 1'b0;
          dreq_d = '0;
          if (is_load_q) begin
            data_wb_d  = (wos_q == WOS_MEM) ? load_ext_c : alt_q;
            wb_valid_d = 1'b1;
            state_d    = ST_WB;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          dreq_d    = '0;
          bus_err_d = 1'b1;
          state_d   = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      dreq_q     <= '0;
      is_load_q  <= 1'b0;
      wos_q      <= WOS_ALU;
      whb_q      <= WHB_BYTE;
      su_q       <= 1'b0;
      addr_lo_q  <= 2'b00;
      alt_q      <= '0;
      func3_q    <= 3'b000;
      in_ready_q <= 1'b1;
      data_wb_q  <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      dreq_q     <= dreq_d;
      is_load_q  <= is_load_d;
      wos_q      <= wos_d;
      whb_q      <= whb_d;
      su_q       <= su_d;
      addr_lo_q  <= addr_lo_d;
      alt_q      <= alt_d;
      func3_q    <= func3_d;
      in_ready_q <= in_ready_d;
      data_wb_q  <= data_wb_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
      bus_err_q  <= bus_err_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign dmem_req   = req_q;
  assign dmem_we    = dreq_q.we;
  assign dmem_addr  = dreq_q.addr;
  assign dmem_wdata = dreq_q.wdata;
  assign dmem_wstrb = dreq_q.wstrb;
  assign Data_WB    = data_wb_q;
  assign wb_valid   = wb_valid_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_wb_unit.sv
// Scoreboard bench for mem_wb_unit: randomized instructions, a reference model of the
// access rules, a reactive data memory and a negedge monitor that checks every output event.
module tb_mem_wb_unit;

  localparam int unsigned TIMEOUT = 4;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam int K_WB   = 0;
  localparam int K_MIS  = 1;
  localparam int K_BERR = 2;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic [1:0]  wos;
  logic [1:0]  whb;
  logic        su;
  logic [31:0] alu_result;
  logic [31:0] store_data;
  logic [31:0] imm;
  logic [31:0] PC_4;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic [31:0] Data_WB;
  logic        wb_valid;
  logic        misalign;
  logic        bus_err;

  mem_wb_unit #(.DW(32), .TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .opcode     (opcode),
    .func3      (func3),
    .wos        (wos),
    .whb        (whb),
    .su         (su),
    .alu_result (alu_result),
    .store_data (store_data),
    .imm        (imm),
    .PC_4       (PC_4),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_ready (dmem_ready),
    .dmem_rdata (dmem_rdata),
    .Data_WB    (Data_WB),
    .wb_valid   (wb_valid),
    .misalign   (misalign),
    .bus_err    (bus_err)
  );

  typedef struct {
    int          kind;
    logic [31:0] data;
  } res_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          w;
    logic [31:0] rdata;
    bit          abort;
  } req_t;

  res_t res_q[$];
  req_t req_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference model: derive the expected memory request and result from the access rules.
  task automatic issue(input logic [6:0] op, input logic [1:0] wos_i, input logic [1:0] whb_i,
                       input logic su_i, input logic [31:0] alu, input logic [31:0] sd,
                       input logic [31:0] im, input logic [31:0] pc4, input int w,
                       input logic [31:0] rd, input bit abort);
    res_t        r;
    req_t        m;
    int          size;
    int          off;
    int          n;
    logic [31:0] alt;
    logic [31:0] v;
    bit          is_ld;
    bit          is_st;
    is_ld = (op == OP_LOAD);
    is_st = (op == OP_STORE);
    size  = (whb_i == 2'd0) ? 1 : (whb_i == 2'd1) ? 2 : 4;
    off   = int'(alu % 4);
    alt   = (wos_i == 2'd2) ? pc4 : (wos_i == 2'd3) ? im : alu;
    if (!is_ld && !is_st) begin
      r.kind = K_WB; r.data = alt; res_q.push_back(r);
    end else if ((alu % size) != 0) begin
      r.kind = K_MIS; r.data = 32'h0; res_q.push_back(r);
    end else begin
      m.we    = is_st;
      m.addr  = alu - 32'(off);
      m.wdata = (size == 1) ? 32'(sd[7:0]) * 32'h01010101 :
                (size == 2) ? 32'(sd[15:0]) * 32'h00010001 : sd;
      m.wstrb = 4'(((1 << size) - 1) << off);
      m.w     = w;
      m.rdata = rd;
      m.abort = abort;
      req_q.push_back(m);
      if (!abort) begin
        if (w >= int'(TIMEOUT)) begin
          r.kind = K_BERR; r.data = 32'h0; res_q.push_back(r);
        end else if (is_ld) begin
          v = rd >> (8 * off);
          if (size == 1) begin
            v = v & 32'hFF;
            if (su_i && v[7]) v = v | 32'hFFFFFF00;
          end else if (size == 2) begin
            v = v & 32'hFFFF;
            if (su_i && v[15]) v = v | 32'hFFFF0000;
          end
          r.kind = K_WB; r.data = (wos_i == 2'd1) ? v : alt; res_q.push_back(r);
        end
      end
    end
    // While busy, wiggle in_valid with junk; the unit must ignore it.
    n = 0;
    while (!in_ready) begin
      in_valid   = 1'($urandom_range(0, 1));
      opcode     = 7'($urandom);
      whb        = 2'($urandom);
      wos        = 2'($urandom);
      alu_result = $urandom;
      @(posedge clk); #1;
      n++;
      if (n > 200) begin
        $display("FAIL in_ready_wait got=0 exp=1");
        $fatal(1, "in_ready never returned");
      end
    end
    in_valid   = 1'b1;
    opcode     = op;
    func3      = 3'($urandom);
    wos        = wos_i;
    whb        = whb_i;
    su         = su_i;
    alu_result = alu;
    store_data = sd;
    imm        = im;
    PC_4       = pc4;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Monitor and reactive memory, all on the falling edge.
  bit          rst_prev   = 1'b1;
  logic [31:0] last_wb    = 32'h0;
  int          req_cycles = 0;
  bit          req_active = 1'b0;
  int          cyc        = 0;
  int          kind;
  int          exp_cycles;
  res_t        er;
  req_t        em;

  always @(negedge clk) begin
    cyc++;
    if (!rst_prev) begin
      check(in_ready && !dmem_req && !dmem_we && !wb_valid && !misalign && !bus_err,
            "reset_flags", {26'h0, in_ready, dmem_req, dmem_we, wb_valid, misalign, bus_err}, 32'h20);
      check(Data_WB == 32'h0, "reset_data_wb", Data_WB, 32'h0);
      check((dmem_addr | dmem_wdata | 32'(dmem_wstrb)) == 32'h0, "reset_dmem_bus",
            dmem_addr | dmem_wdata | 32'(dmem_wstrb), 32'h0);
      last_wb = 32'h0;
    end else if (wb_valid || misalign || bus_err) begin
      kind = wb_valid ? K_WB : misalign ? K_MIS : K_BERR;
      if (int'(wb_valid) + int'(misalign) + int'(bus_err) > 1)
        check(1'b0, "result_overlap", {29'h0, wb_valid, misalign, bus_err}, 32'h0);
      if (res_q.size() == 0) begin
        check(1'b0, "unexpected_result", 32'(kind), 32'hFFFFFFFF);
      end else begin
        er = res_q.pop_front();
        check(kind == er.kind, "result_kind", 32'(kind), 32'(er.kind));
        if (er.kind == K_WB) begin
          check(Data_WB == er.data, "data_wb", Data_WB, er.data);
          last_wb = er.data;
        end
      end
      if (!wb_valid) check(Data_WB == last_wb, "data_wb_hold", Data_WB, last_wb);
    end else begin
      check(Data_WB == last_wb, "data_wb_hold", Data_WB, last_wb);
    end

    if (dmem_req) begin
      if (req_q.size() == 0) begin
        check(1'b0, "unexpected_req", dmem_addr, 32'h0);
        dmem_ready = 1'b0;
      end else begin
        em = req_q[0];
        req_active = 1'b1;
        req_cycles++;
        check(dmem_we == em.we, "req_we", 32'(dmem_we), 32'(em.we));
        check(dmem_addr == em.addr, "req_addr", dmem_addr, em.addr);
        if (em.we) begin
          check(dmem_wdata == em.wdata, "req_wdata", dmem_wdata, em.wdata);
          check(dmem_wstrb == em.wstrb, "req_wstrb", 32'(dmem_wstrb), 32'(em.wstrb));
        end
        if (req_cycles == em.w + 1) begin
          dmem_ready = 1'b1;
          dmem_rdata = em.rdata;
        end else begin
          dmem_ready = 1'b0;
          dmem_rdata = $urandom;
        end
      end
    end else begin
      dmem_ready = 1'b0;
      if (req_active) begin
        em = req_q.pop_front();
        exp_cycles = (em.w >= int'(TIMEOUT)) ? int'(TIMEOUT) : em.w + 1;
        if (!em.abort) check(req_cycles == exp_cycles, "req_cycles", 32'(req_cycles), 32'(exp_cycles));
        req_active = 1'b0;
        req_cycles = 0;
      end
    end

    if (done) begin
      check(res_q.size() == 0 && req_q.size() == 0, "drain", 32'(res_q.size() + req_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    if (cyc > 60000) begin
      check(1'b0, "watchdog", 32'(cyc), 32'd60000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
    rst_prev = rst;
  end

  logic [6:0]  op;
  logic [1:0]  rwhb;
  logic [31:0] ralu;
  int          sel;
  int          n;

  initial begin
    rst = 1'b0; in_valid = 1'b0; opcode = 7'h0; func3 = 3'h0; wos = 2'h0; whb = 2'h0;
    su = 1'b0; alu_result = 32'h0; store_data = 32'h0; imm = 32'h0; PC_4 = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    issue(OP_ALU,   2'b00, 2'b10, 1'b0, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    issue(OP_LOAD,  2'b01, 2'b00, 1'b1, 32'h0000_0103, 32'h0, 32'h0, 32'h0, 2, 32'h80FF_0000, 1'b0);
    issue(OP_LOAD,  2'b01, 2'b00, 1'b0, 32'h0000_0103, 32'h0, 32'h0, 32'h0, 2, 32'h80FF_0000, 1'b0);
    issue(OP_STORE, 2'b00, 2'b01, 1'b0, 32'h0000_0202, 32'hAAAA_BEEF, 32'h0, 32'h0, 1, 32'h0, 1'b0);
    issue(OP_LOAD,  2'b01, 2'b10, 1'b1, 32'h0000_0101, 32'h0, 32'h0, 32'h0, 0, 32'h0, 1'b0);
    issue(OP_LOAD,  2'b01, 2'b10, 1'b0, 32'h0000_0400, 32'h0, 32'h0, 32'h0, 10, 32'h1234_5678, 1'b0);
    issue(OP_LOAD,  2'b01, 2'b11, 1'b1, 32'h0000_0404, 32'h0, 32'h0, 32'h0, 0, 32'hCAFE_F00D, 1'b0);

    // Reset while a load waits on memory; the transaction is discarded.
    issue(OP_LOAD,  2'b01, 2'b10, 1'b0, 32'h0000_0500, 32'h0, 32'h0, 32'h0, 50, 32'h0, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    issue(OP_JAL,   2'b10, 2'b10, 1'b0, 32'h0000_1000, 32'h0, 32'h0, 32'h0000_0044, 0, 32'h0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      sel  = $urandom_range(0, 9);
      op   = (sel < 4) ? OP_LOAD : (sel < 7) ? OP_STORE : (sel == 7) ? OP_ALU :
             (sel == 8) ? OP_JAL : OP_LUI;
      rwhb = 2'($urandom);
      ralu = $urandom;
      if ($urandom_range(0, 2) != 0)
        ralu[1:0] = (rwhb == 2'd0) ? ralu[1:0] : (rwhb == 2'd1) ? {ralu[1], 1'b0} : 2'b00;
      issue(op, 2'($urandom), rwhb, 1'($urandom), ralu, $urandom, $urandom, $urandom,
            $urandom_range(0, 5), $urandom, 1'b0);
    end

    n = 0;
    while ((res_q.size() != 0 || req_q.size() != 0) && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (5) @(posedge clk);
    done = 1'b1;
  end

endmodule
